// File: rtl/sequencer_recorder.sv
// sequencer_recorder
//   Watches six bit-bus inputs and records table frames {pattern, duration}, the
//   inverse of the sequencer's playback. Frames are stored in an on-chip FIFO and
//   drained by software one 32-bit word at a time (word0 = pattern, word1 = duration).
//
// Ports:
//   clk_i        system clock
//   reset_i      asynchronous active-low reset
//   enable_i     recording gate; a rising edge while ARMED starts recording
//   inpa_i..f_i  recorded bits, pattern = {inpf..inpa}
//   PRESCALE     clocks per duration tick (0 behaves as 1)
//   ARM          strobe: clear FIFO, overflow and word select, enter ARMED
//   TABLE_RSTB   strobe: pop one 32-bit word into TABLE_RDATA
//   TABLE_RDATA  registered read word
//   FRAME_COUNT  complete frames held in the FIFO
//   active_o     high while recording
//   overflow_o   sticky: a frame was dropped because the FIFO was full
module sequencer_recorder #(
   parameter int unsigned AW = 9
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        enable_i,
   input  logic        inpa_i,
   input  logic        inpb_i,
   input  logic        inpc_i,
   input  logic        inpd_i,
   input  logic        inpe_i,
   input  logic        inpf_i,
   input  logic [31:0] PRESCALE,
   input  logic        ARM,
   input  logic        TABLE_RSTB,
   output logic [31:0] TABLE_RDATA,
   output logic [15:0] FRAME_COUNT,
   output logic        active_o,
   output logic        overflow_o
);

   typedef enum logic [1:0] {StIdle, StArmed, StRecord} state_e;

   localparam int unsigned Depth = 2 ** AW;

   state_e        r_state, w_state_nxt;
   logic          r_en_prev;
   logic [5:0]    r_pat, w_pat_nxt;
   logic [31:0]   r_pre, w_pre_nxt;
   logic [31:0]   r_dur, w_dur_nxt;
   logic          r_ovf, w_ovf_nxt;
   logic [AW:0]   r_wr_ptr, r_rd_ptr;
   logic          r_sel;
   logic [31:0]   r_rdata;
   logic [37:0]   r_mem [Depth];

   logic [5:0]    w_pat;
   logic          w_rise;
   logic [31:0]   w_pre_max;
   logic          w_tick;
   logic          w_close;
   logic          w_push;
   logic          w_full;
   logic          w_empty;
   logic [AW:0]   w_count;

   assign w_pat     = {inpf_i, inpe_i, inpd_i, inpc_i, inpb_i, inpa_i};
   assign w_rise    = enable_i & ~r_en_prev;
   assign w_pre_max = (PRESCALE == 32'd0) ? 32'd1 : PRESCALE;
   // >= rather than == so a PRESCALE lowered mid-frame cannot strand the counter
   assign w_tick    = (r_pre + 32'd1) >= w_pre_max;

   // Extra MSB on the pointers separates full from empty
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_count = r_wr_ptr - r_rd_ptr;

   // Next-state / frame logic
   always_comb begin
      w_state_nxt = r_state;
      w_pat_nxt   = r_pat;
      w_pre_nxt   = r_pre;
      w_dur_nxt   = r_dur;
      w_ovf_nxt   = r_ovf;
      w_close     = 1'b0;
      if (ARM) begin
         w_state_nxt = StArmed;
         w_ovf_nxt   = 1'b0;
      end else begin
         case (r_state)
            StIdle: ;
            StArmed: begin
               if (w_rise) begin
                  w_state_nxt = StRecord;
                  w_pat_nxt   = w_pat;
                  w_pre_nxt   = 32'd0;
                  w_dur_nxt   = 32'd0;
               end
            end
            StRecord: begin
               if (!enable_i) begin
                  // Disable wins over a coincident pattern change: one frame, old pattern
                  w_close     = 1'b1;
                  w_state_nxt = StIdle;
               end else if (w_pat != r_pat) begin
                  w_close   = 1'b1;
                  w_pat_nxt = w_pat;
                  w_pre_nxt = 32'd0;
                  w_dur_nxt = 32'd0;
               end else if (r_dur == 32'hFFFF_FFFF) begin
                  w_close   = 1'b1;
                  w_pre_nxt = 32'd0;
                  w_dur_nxt = 32'd0;
               end else if (w_tick) begin
                  w_pre_nxt = 32'd0;
                  w_dur_nxt = r_dur + 32'd1;
               end else begin
                  w_pre_nxt = r_pre + 32'd1;
               end
               // A pop in the same cycle does not free space in time: full is full
               if (w_close && w_full) begin
                  w_state_nxt = StIdle;
                  w_ovf_nxt   = 1'b1;
               end
            end
            default: w_state_nxt = StIdle;
         endcase
      end
   end

   assign w_push = w_close & ~w_full;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_state   <= StIdle;
         r_en_prev <= 1'b0;
         r_pat     <= '0;
         r_pre     <= '0;
         r_dur     <= '0;
         r_ovf     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_en_prev <= enable_i;
         r_pat     <= w_pat_nxt;
         r_pre     <= w_pre_nxt;
         r_dur     <= w_dur_nxt;
         r_ovf     <= w_ovf_nxt;
      end
   end

   // Frame storage: single write port, read only through the registered readout below
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= {r_pat, r_dur};
      end
   end

   // FIFO pointers and word-by-word readout
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_sel    <= 1'b0;
         r_rdata  <= '0;
      end else if (ARM) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_sel    <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (TABLE_RSTB) begin
            if (w_empty) begin
               r_rdata <= '0;
            end else if (!r_sel) begin
               r_rdata <= {26'd0, r_mem[r_rd_ptr[AW-1:0]][37:32]};
               r_sel   <= 1'b1;
            end else begin
               r_rdata  <= r_mem[r_rd_ptr[AW-1:0]][31:0];
               r_sel    <= 1'b0;
               r_rd_ptr <= r_rd_ptr + 1'b1;
            end
         end
      end
   end

   assign TABLE_RDATA = r_rdata;
   assign FRAME_COUNT = 16'(w_count);
   assign active_o    = (r_state == StRecord);
   assign overflow_o  = r_ovf;

endmodule
